// File: rtl/mpsoc_wb_pkg.sv
// Wishbone B3 cycle-type constants and master FSM state encoding.
// The same constants are used by mpsoc_wb_spram.
package mpsoc_wb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef logic [1:0] wbm_state_t;
  localparam wbm_state_t ST_IDLE = 2'd0;
  localparam wbm_state_t ST_BUS  = 2'd1;
  localparam wbm_state_t ST_RESP = 2'd2;
endpackage

// File: rtl/mpsoc_wb_spram_master.sv
// Wishbone B3 initiator: turns one command into a classic or incrementing-burst cycle,
// streaming write data in and read data out, with one response pulse per command.
module mpsoc_wb_spram_master
  import mpsoc_wb_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 256,
  localparam int LW = $clog2(MAX_BURST),
  localparam int SW = DW / 8,
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_adr,
  input  logic          cmd_we,
  input  logic [SW-1:0] cmd_sel,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [SW-1:0] wb_sel_o,
  output logic          wb_we_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic [DW-1:0] wb_dat_i
);

  wbm_state_t    state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          we_q, we_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW:0]   rem_q, rem_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic in_bus, hs, beat_ok, beat_err, tmo_hit, last_beat;

  assign in_bus    = (state_q == ST_BUS);
  assign last_beat = (rem_q == (LW+1)'(1));
  // Writes stall the strobe (not the cycle) while the data stream is empty.
  assign hs        = in_bus & (~we_q | wr_valid);
  assign beat_err  = hs & wb_err_i;
  assign beat_ok   = hs & wb_ack_i & ~wb_err_i;
  assign tmo_hit   = hs & ~wb_ack_i & ~wb_err_i & (tmo_q == TW'(TIMEOUT - 1));

  assign cmd_ready = (state_q == ST_IDLE);
  assign wr_ready  = beat_ok & we_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = (state_q == ST_RESP) & err_q;

  assign wb_cyc_o  = in_bus;
  assign wb_stb_o  = hs;
  assign wb_adr_o  = in_bus ? adr_q : '0;
  assign wb_sel_o  = in_bus ? sel_q : '0;
  assign wb_we_o   = in_bus & we_q;
  assign wb_dat_o  = (in_bus & we_q) ? wr_data : '0;
  assign wb_bte_o  = BTE_LINEAR;
  assign wb_cti_o  = !in_bus            ? CTI_CLASSIC :
                     (len_q == '0)      ? CTI_CLASSIC :
                     last_beat          ? CTI_EOB     : CTI_INCR;

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    we_d       = we_q;
    sel_d      = sel_q;
    len_d      = len_q;
    rem_d      = rem_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = beat_ok & ~we_q;
    if (beat_ok & ~we_q) rd_data_d = wb_dat_i;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_BUS;
          adr_d   = cmd_adr;
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          len_d   = cmd_len;
          rem_d   = {1'b0, cmd_len} + (LW+1)'(1);
          tmo_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_BUS: begin
        // Error outranks a simultaneous ack; remaining beats are dropped.
        if (beat_err | tmo_hit) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end else if (beat_ok) begin
          adr_d = adr_q + AW'(1);
          rem_d = rem_q - (LW+1)'(1);
          tmo_d = '0;
          if (last_beat) state_d = ST_RESP;
        end else if (hs) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
    adr_q <= adr_d;
    we_q  <= we_d;
    sel_q <= sel_d;
    len_q <= len_d;
  end

endmodule

// File: tb/tb_mpsoc_wb_spram_master.sv
// Directed bench for the Wishbone master against a small zero-wait-state slave model
// with error injection, ack suppression and simultaneous ack+err.
module tb_mpsoc_wb_spram_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_adr = '0;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [3:0]  cmd_len = '0;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rsp_valid, rsp_err;
  logic [7:0]  wb_adr;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err;
  logic [1:0]  wb_bte;
  logic [2:0]  wb_cti;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mpsoc_wb_spram_master #(.DW(32), .AW(8), .MAX_BURST(16), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr), .cmd_we(cmd_we),
    .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_bte_o(wb_bte), .wb_cti_o(wb_cti), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_dat_i(wb_dat_i)
  );

  // Slave model: combinational ack, optional error on a chosen beat, optional no-ack.
  logic [31:0] mem [256];
  logic        slv_noack = 1'b0;
  logic        slv_both  = 1'b0;
  int          err_at    = -1;
  int          beat_cnt  = 0;

  assign wb_err   = wb_cyc & wb_stb & (beat_cnt == err_at);
  assign wb_ack   = wb_cyc & wb_stb & ~slv_noack & (~wb_err | slv_both);
  assign wb_dat_i = mem[wb_adr];

  always @(posedge clk) begin
    if (!wb_cyc) beat_cnt <= 0;
    else if (wb_ack) beat_cnt <= beat_cnt + 1;
    if (wb_cyc & wb_stb & wb_ack & ~wb_err & wb_we) begin
      for (int k = 0; k < 4; k++)
        if (wb_sel[k]) mem[wb_adr][8*k +: 8] <= wb_dat_o[8*k +: 8];
    end
  end

  // Write stream source: one global ordered word list; a 3-cycle gap follows word 10.
  logic [31:0] wbuf [32];
  int widx = 0;
  int stall_left = 0;
  assign wr_data  = wbuf[widx];
  assign wr_valid = (stall_left == 0);

  always @(posedge clk) begin
    if (wr_ready) widx <= widx + 1;
    if (wr_ready && widx == 10) stall_left <= 3;
    else if (stall_left > 0) stall_left <= stall_left - 1;
  end

  // Bus monitor, sampled mid-cycle.
  logic [7:0]  log_adr [64];
  logic [2:0]  log_cti [64];
  logic [31:0] rdl [64];
  int nlog = 0, nrd = 0, nrsp = 0, nstall = 0, ncyc = 0, nwr = 0;

  always @(negedge clk) begin
    if (wb_cyc & wb_stb & wb_ack & ~wb_err) begin
      log_adr[nlog] <= wb_adr;
      log_cti[nlog] <= wb_cti;
      nlog <= nlog + 1;
    end
    if (rd_valid) begin
      rdl[nrd] <= rd_data;
      nrd <= nrd + 1;
    end
    if (rsp_valid) nrsp <= nrsp + 1;
    if (wb_cyc & ~wb_stb) nstall <= nstall + 1;
    if (wb_cyc) ncyc <= ncyc + 1;
    if (wr_ready) nwr <= nwr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic w, input logic [3:0] s,
                       input logic [3:0] l);
    int t;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cmd_ready) chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_adr = a; cmd_we = w; cmd_sel = s; cmd_len = l; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic w,
                     input logic [3:0] s, input logic [3:0] l, output logic e);
    logic ok;
    ok = 1'b0;
    e  = 1'b0;
    issue(a, w, s, l);
    for (int t = 0; t < 100 && !ok; t++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        e  = rsp_err;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk({tag, "_rsp_seen"}, 32'(ok), 32'd1);
    @(negedge clk); #1;
  endtask

  initial begin
    logic e;
    int b, r, c, s, w, p;
    wbuf[0] = 32'hDEADBEEF;
    for (int i = 1; i <= 4; i++) wbuf[i] = 32'(i);
    for (int i = 0; i < 4; i++) wbuf[5 + i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 4; i++) wbuf[9 + i] = 32'hB000_0000 + 32'(i);
    wbuf[13] = 32'hC0DE_C0DE;
    for (int i = 14; i < 32; i++) wbuf[i] = 32'h5A5A_0000 + 32'(i);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_stb", 32'(wb_stb), 32'd0);
    chk("rst_adr", 32'(wb_adr), 32'd0);
    chk("rst_cti", 32'(wb_cti), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // 1: single write and readback
    b = nlog;
    run("t1w", 8'h10, 1'b1, 4'hF, 4'd0, e);
    chk("t1w_err", 32'(e), 32'd0);
    chk("t1w_adr", 32'(log_adr[b]), 32'h10);
    chk("t1w_cti", 32'(log_cti[b]), 32'h0);
    r = nrd;
    run("t1r", 8'h10, 1'b0, 4'hF, 4'd0, e);
    chk("t1r_err", 32'(e), 32'd0);
    chk("t1r_data", rdl[r], 32'hDEADBEEF);

    // 2: 4-word burst write, burst read back
    run("t2w", 8'h20, 1'b1, 4'hF, 4'd3, e);
    b = nlog; r = nrd;
    run("t2r", 8'h20, 1'b0, 4'hF, 4'd3, e);
    chk("t2r_err", 32'(e), 32'd0);
    chk("t2r_beats", 32'(nlog - b), 32'd4);
    chk("t2r_rdcnt", 32'(nrd - r), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2r_adr", 32'(log_adr[b + i]), 32'h20 + 32'(i));
      chk("t2r_cti", 32'(log_cti[b + i]), (i == 3) ? 32'h7 : 32'h2);
      chk("t2r_data", rdl[r + i], 32'(i + 1));
    end

    // 3: burst wraps at the top of the address space
    b = nlog;
    run("t3w", 8'hFE, 1'b1, 4'hF, 4'd3, e);
    chk("t3_adr0", 32'(log_adr[b]), 32'hFE);
    chk("t3_adr1", 32'(log_adr[b + 1]), 32'hFF);
    chk("t3_adr2", 32'(log_adr[b + 2]), 32'h00);
    chk("t3_adr3", 32'(log_adr[b + 3]), 32'h01);
    r = nrd;
    run("t3r", 8'h00, 1'b0, 4'hF, 4'd0, e);
    chk("t3r_data", rdl[r], 32'hA000_0002);

    // 4: write stream stalls three cycles mid-burst
    s = nstall; b = nlog;
    run("t4w", 8'h40, 1'b1, 4'hF, 4'd3, e);
    chk("t4_stall_cycles", 32'(nstall - s), 32'd3);
    chk("t4_beats", 32'(nlog - b), 32'd4);
    chk("t4_err", 32'(e), 32'd0);
    r = nrd;
    run("t4r", 8'h40, 1'b0, 4'hF, 4'd3, e);
    for (int i = 0; i < 4; i++) chk("t4r_data", rdl[r + i], 32'hB000_0000 + 32'(i));

    // ack and err together: err wins and the write word is left in the stream
    slv_both = 1'b1; err_at = 0; w = nwr;
    run("tb_both", 8'h50, 1'b1, 4'hF, 4'd1, e);
    chk("both_err", 32'(e), 32'd1);
    chk("both_no_consume", 32'(nwr - w), 32'd0);
    slv_both = 1'b0; err_at = -1;
    run("tb_both_w", 8'h51, 1'b1, 4'hF, 4'd0, e);
    r = nrd;
    run("tb_both_r", 8'h51, 1'b0, 4'hF, 4'd0, e);
    chk("both_word_kept", rdl[r], 32'hC0DE_C0DE);

    // 5: error on the second beat of a 4-beat read
    err_at = 1; r = nrd; c = ncyc;
    run("t5r", 8'h20, 1'b0, 4'hF, 4'd3, e);
    chk("t5_err", 32'(e), 32'd1);
    chk("t5_rdcnt", 32'(nrd - r), 32'd1);
    chk("t5_rd0", rdl[r], 32'd1);
    chk("t5_cyc_cycles", 32'(ncyc - c), 32'd2);
    err_at = -1;

    // 6: slave never acks -> timeout after 16 strobed cycles
    slv_noack = 1'b1; r = nrd; c = ncyc;
    run("t6r", 8'h30, 1'b0, 4'hF, 4'd3, e);
    chk("t6_err", 32'(e), 32'd1);
    chk("t6_cyc_cycles", 32'(ncyc - c), 32'd16);
    chk("t6_rdcnt", 32'(nrd - r), 32'd0);

    // reset during a burst releases the bus with no response
    issue(8'h30, 1'b0, 4'hF, 4'd3);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_cyc_before_rst", 32'(wb_cyc), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_cyc", 32'(wb_cyc), 32'd0);
    chk("mid_rst_stb", 32'(wb_stb), 32'd0);
    rst = 1'b0;
    p = nrsp; r = nrd;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_rst_no_rsp", 32'(nrsp - p), 32'd0);
    chk("mid_rst_no_rd", 32'(nrd - r), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    slv_noack = 1'b0;
    r = nrd;
    run("recover", 8'h10, 1'b0, 4'hF, 4'd0, e);
    chk("recover_data", rdl[r], 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end
endmodule
